bp_resolve_unit: RTL
====================

Name: bp_resolve_unit

Overview:
- Resolution end of the branch-prediction interface.
- Records every fetch-time prediction in an in-order queue and pairs it with the actual outcome when the branch resolves in EX.
- Detects mispredictions and produces the predictor update (enable, PC, outcome), a pipeline flush and a redirect PC.
- Keeps branch and misprediction statistics counters.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, 2..64.
- XLEN, 32, address width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push_valid  in  1  fetch issues a predicted branch this cycle
- push_pc  in  XLEN  PC of that branch
- push_pred_taken  in  1  predicted direction
- push_pred_target  in  XLEN  predicted target, used only when predicted taken
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- occupancy  out  $clog2(DEPTH)+1  current entry count
- res_valid  in  1  oldest in-flight branch resolves in EX this cycle
- res_taken  in  1  actual direction
- res_target  in  XLEN  actual target
- upd_en  out  1  predictor update strobe
- upd_pc  out  XLEN  PC of the updated branch
- upd_taken  out  1  actual direction sent to the predictor
- flush  out  1  misprediction: kill younger instructions
- redirect_pc  out  XLEN  correct fetch PC, valid when flush=1
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating
- err_overflow  out  1  sticky: push_valid while full
- err_underflow  out  1  sticky: res_valid while empty

Behaviour:
- Reset (rst=1 at posedge):
  - head=tail=occupancy=0; empty=1, full=0.
  - upd_en=0, flush=0, upd_pc=0, upd_taken=0, redirect_pc=0.
  - Counters and sticky error flags cleared; queue contents don't-care.
  - Reset mid-operation discards all in-flight entries.
- Queue: circular buffer with head/tail pointers wrapping modulo DEPTH. full and empty are derived from registered occupancy.
- Push: accepted when push_valid=1 and full=0 and no flush this cycle. Writes {pc, pred_taken, pred_target} at tail, then tail+1.
- Push while full: dropped, err_overflow set. This applies even when res_valid pops in the same cycle; no bypass.
- Resolve: res_valid=1 and empty=0 pops the head entry.
  - mispredict = (pred_taken != res_taken) | (res_taken & pred_target != res_target).
- Resolve while empty: ignored, err_underflow set, no outputs asserted.
- Outputs, registered, asserted the cycle after a valid resolve for exactly 1 cycle:
  - upd_en=1, upd_pc=entry.pc, upd_taken=res_taken.
  - If mispredict: flush=1; redirect_pc = res_taken ? res_target : entry.pc+4 (mod 2^XLEN).
- Flush cycle (mispredict detected): all younger entries are wrong-path. head=tail=occupancy=0 next cycle. A push in the same cycle is discarded and does not raise err_overflow.
- Simultaneous push and correct resolve: both take effect; occupancy unchanged.
- Counters: on each valid resolve branch_cnt+1; on mispredict also mispred_cnt+1. Both saturate at all-ones.
- No back-pressure to EX. Fetch must stall on full.

Decomposition:
- Package bp_pkg holds:
  - typedef bp_entry_t {logic [XLEN-1:0] pc; logic pred_taken; logic [XLEN-1:0] pred_target;}
  - localparam INSTR_BYTES=4
  - typedef bp_update_t {en, pc, taken}, to be shared with the predictor side.
- One sub-module, bp_inflight_fifo: parameterised circular FIFO with push, pop, clear, full, empty, count.
- The top level holds the compare, the output registers and the counters.

Test Plan:
- Reset, then push pc=0x100 pred_taken=0; resolve res_taken=0 -> next cycle upd_en=1, upd_pc=0x100, upd_taken=0, flush=0; branch_cnt=1, mispred_cnt=0.
- Push pc=0x200 pred_taken=0; resolve res_taken=1 res_target=0x300 -> flush=1, redirect_pc=0x300, mispred_cnt=1.
- Push pc=0x400 pred_taken=1 target=0x500; resolve taken=1 target=0x600 -> flush=1, redirect_pc=0x600. Push pc=0x404 pred_taken=1 target=0x500; resolve taken=0 -> redirect_pc=0x408.
- Push 3 entries, resolve the first as mispredicted while push_valid=1 -> occupancy=0 next cycle, empty=1, err_overflow=0.
- Push 8 entries (full=1), push a 9th -> dropped, err_overflow=1. Pop all 8 correctly predicted -> upd_pc sequence matches push order across pointer wrap.
- res_valid with queue empty -> err_underflow=1, upd_en=0. Assert rst mid-stream with 5 entries -> occupancy=0 and all flags cleared the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the branch-prediction
//               resolve path and the predictor update interface.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_XLEN     = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               pred_taken;
        logic [BP_XLEN-1:0] pred_target;
    } bp_entry_t;

    typedef struct packed {
        logic               en;
        logic [BP_XLEN-1:0] pc;
        logic               taken;
    } bp_update_t;

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_inflight_fifo
// Description : Circular FIFO of in-flight branch entries with a
//               synchronous clear that discards every entry at once.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_inflight_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full     = (r_count == C_FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_head];

    assign w_push_ok  = i_push & ~o_full;
    assign w_pop_ok   = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + 1'b1;
            if (w_pop_ok)  r_head <= r_head + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_tail] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bp_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : bp_resolve_unit
// Description : Pairs fetch-time predictions with EX outcomes, flags
//               mispredictions, drives predictor updates and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [XLEN-1:0]          push_pc,
    input  logic                     push_pred_taken,
    input  logic [XLEN-1:0]          push_pred_target,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [XLEN-1:0]          res_target,
    output logic                     upd_en,
    output logic [XLEN-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic                     flush,
    output logic [XLEN-1:0]          redirect_pc,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    localparam int ENTRY_W = 2*XLEN + 1;

    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head_data;
    logic [XLEN-1:0]    w_head_pc;
    logic               w_head_pred_taken;
    logic [XLEN-1:0]    w_head_pred_target;
    logic [XLEN-1:0]    w_fallthrough_pc;
    logic               w_resolve;
    logic               w_mispredict;
    logic               w_push_ok;

    logic               r_upd_en;
    logic [XLEN-1:0]    r_upd_pc;
    logic               r_upd_taken;
    logic               r_flush;
    logic [XLEN-1:0]    r_redirect_pc;
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_mispred_cnt;
    logic               r_err_overflow;
    logic               r_err_underflow;

    assign w_push_data        = {push_pc, push_pred_taken, push_pred_target};
    assign w_head_pc          = w_head_data[ENTRY_W-1 -: XLEN];
    assign w_head_pred_taken  = w_head_data[XLEN];
    assign w_head_pred_target = w_head_data[XLEN-1:0];
    assign w_fallthrough_pc   = w_head_pc + XLEN'(INSTR_BYTES);

    assign w_resolve    = res_valid & ~empty;
    assign w_mispredict = w_resolve &
                          ((w_head_pred_taken != res_taken) |
                           (res_taken & (w_head_pred_target != res_target)));
    // Anything fetched alongside a mispredict is wrong-path and is dropped.
    assign w_push_ok    = push_valid & ~full & ~w_mispredict;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push_ok),
        .i_push_data (w_push_data),
        .i_pop       (w_resolve),
        .i_clear     (w_mispredict),
        .o_pop_data  (w_head_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_en        <= 1'b0;
            r_upd_pc        <= '0;
            r_upd_taken     <= 1'b0;
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_branch_cnt    <= '0;
            r_mispred_cnt   <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_upd_en <= w_resolve;
            r_flush  <= w_mispredict;
            if (w_resolve) begin
                r_upd_pc    <= w_head_pc;
                r_upd_taken <= res_taken;
                if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispredict) begin
                r_redirect_pc <= res_taken ? res_target : w_fallthrough_pc;
                if (r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
            if (push_valid && full && !w_mispredict) r_err_overflow  <= 1'b1;
            if (res_valid && empty)                  r_err_underflow <= 1'b1;
        end
    end

    assign upd_en        = r_upd_en;
    assign upd_pc        = r_upd_pc;
    assign upd_taken     = r_upd_taken;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign branch_cnt    = r_branch_cnt;
    assign mispred_cnt   = r_mispred_cnt;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire
